// File: rtl/asy_fifo_pkg.sv
// Shared widths and FSM state type for the SPI receive byte buffer.
// Derived widths follow the default depth and frame size.
package asy_fifo_pkg;

  localparam int MEMDEPTH    = 30;
  localparam int DATA_W      = 8;
  localparam int FRAME_BYTES = 15;
  localparam int OUT_W       = DATA_W * FRAME_BYTES;
  localparam int PTR_W       = $clog2(MEMDEPTH);
  localparam int CNT_W       = $clog2(MEMDEPTH + 1);
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  typedef enum logic {
    IDLE   = 1'b0,
    UNLOAD = 1'b1
  } state_e;

endpackage

// File: rtl/asy_fifo_output_if.sv
// SPI receive buffer bus: byte strobe, frame request and frame output.
// The SPI/test side is master, the buffer is slave.
interface asy_fifo_output_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 120
);

  logic              control_clk_miso;
  logic              read_req;
  logic [DATA_W-1:0] wdata;
  logic [OUT_W-1:0]  data_out;
  logic              spi_cs;

  modport master (
    output control_clk_miso,
    output read_req,
    output wdata,
    input  data_out,
    input  spi_cs
  );

  modport slave (
    input  control_clk_miso,
    input  read_req,
    input  wdata,
    output data_out,
    output spi_cs
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a one-clk pulse on the synchronized rise.
// The pulse is valid in the cycle after the second flop goes high.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d  = {sync_q[1:0], d_i};
  assign pulse_o = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/asy_fifo_output.sv
// SPI receive byte FIFO that unloads 15-byte frames as one wide word.
// Byte 0 of a frame lands in the low bits of data_out.
module asy_fifo_output
  import asy_fifo_pkg::*;
(
  input logic              clk,
  input logic              rst,
  asy_fifo_output_if.slave bus
);

  logic wr_stb;
  logic rd_stb;

  sync_edge_det u_wr_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (bus.control_clk_miso),
    .pulse_o (wr_stb)
  );

  sync_edge_det u_rd_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (bus.read_req),
    .pulse_o (rd_stb)
  );

  logic [DATA_W-1:0] mem_q [MEMDEPTH];
  logic [DATA_W-1:0] wdata_q;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OUT_W-1:0]  asm_q, asm_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              spi_cs_q;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(MEMDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO drops the byte even when a pop happens this cycle.
  assign push = wr_stb && (count_q != CNT_W'(MEMDEPTH));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_ptr_d = rd_ptr_q;
    asm_d    = asm_q;
    data_d   = data_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_stb && count_q >= CNT_W'(FRAME_BYTES)) begin
          state_d = UNLOAD;
          idx_d   = '0;
        end
      end
      UNLOAD: begin
        pop      = 1'b1;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        asm_d[idx_q*DATA_W +: DATA_W] = mem_q[rd_ptr_q];
        if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
          data_d  = asm_d;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    wdata_q <= bus.wdata;
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      asm_q    <= '0;
      data_q   <= '0;
      spi_cs_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      asm_q    <= asm_d;
      data_q   <= data_d;
      spi_cs_q <= (count_q == CNT_W'(MEMDEPTH));
    end
  end

  assign bus.data_out = data_q;
  assign bus.spi_cs   = spi_cs_q;

endmodule

// File: tb/tb_asy_fifo_output.sv
// Randomized and directed bench for the SPI receive frame buffer.
// A byte queue model supplies every expected frame and full flag.
module tb_asy_fifo_output;

  localparam int DEPTH = 30;
  localparam int FB    = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  asy_fifo_output_if #(.DATA_W(8), .OUT_W(120)) bus ();

  asy_fifo_output dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   mq[$];
  logic [119:0] exp_data = '0;

  task automatic chk(input string tag,
                     input logic [119:0] got,
                     input logic [119:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.read_req = 1'b0;
    bus.control_clk_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, '0);
    chk("rst_cs", {119'b0, bus.spi_cs}, 120'd1);
    mq.delete();
    exp_data = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rel_cs", {119'b0, bus.spi_cs}, '0);
  endtask

  task automatic do_write(input logic [7:0] b);
    @(negedge clk);
    bus.wdata = b;
    bus.control_clk_miso = 1'b1;
    repeat (3) @(negedge clk);
    bus.control_clk_miso = 1'b0;
    repeat (3) @(negedge clk);
    if (mq.size() < DEPTH) mq.push_back(b);
    chk("wr_cs", {119'b0, bus.spi_cs},
        {119'b0, mq.size() == DEPTH});
  endtask

  task automatic do_read();
    logic [119:0] old_v;
    logic [119:0] new_v;
    old_v = exp_data;
    new_v = old_v;
    if (mq.size() >= FB) begin
      for (int i = 0; i < FB; i++) new_v[i*8 +: 8] = mq.pop_front();
    end
    @(negedge clk);
    bus.read_req = 1'b1;
    repeat (17) @(posedge clk);
    #1 chk("rd_hold", bus.data_out, old_v);
    @(posedge clk);
    #1 chk("rd_frame", bus.data_out, new_v);
    exp_data = new_v;
    @(negedge clk);
    bus.read_req = 1'b0;
    @(negedge clk);
    chk("rd_cs", {119'b0, bus.spi_cs},
        {119'b0, mq.size() == DEPTH});
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat [15];
    pat = '{8'd1, 8'd2, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70,
            8'd100, 8'd120, 8'd130, 8'd140, 8'd150, 8'd55, 8'd200};
    bus.control_clk_miso = 1'b0;
    bus.read_req = 1'b0;
    bus.wdata = '0;

    do_reset();

    for (int i = 0; i < FB; i++) do_write(pat[i]);
    do_read();
    chk("b0", {112'b0, bus.data_out[7:0]}, 120'd1);
    chk("b1", {112'b0, bus.data_out[15:8]}, 120'd2);
    chk("b14", {112'b0, bus.data_out[119:112]}, 120'd200);

    do_reset();
    for (int i = 0; i < 13; i++) do_write(8'(i + 1));
    do_read();
    do_write(8'd14);
    do_write(8'd15);
    do_read();

    do_reset();
    for (int i = 1; i <= 31; i++) do_write(8'(i));
    do_read();
    do_read();
    do_read();

    do_reset();
    for (int i = 1; i <= 20; i++) do_write(8'(i));
    fork
      do_read();
      for (int i = 21; i <= 45; i++) do_write(8'(i));
    join
    do_read();
    do_read();

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) do_read();
      else do_write(8'($urandom));
    end

    for (int i = 0; i < FB; i++) do_write(8'($urandom));
    @(negedge clk);
    bus.read_req = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    bus.read_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_data", bus.data_out, '0);
    chk("mid_cs", {119'b0, bus.spi_cs}, 120'd1);
    mq.delete();
    exp_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rel_cs", {119'b0, bus.spi_cs}, '0);
    do_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
